// File: rtl/prng_seq_ctrl.sv
// Sequencer for the free-running 13-bit two-step LFSR of a Massey-Rueppel PRNG:
// seed load, warm-up discard, valid/ready word delivery and all-zero lock-up guard.
module prng_seq_ctrl #(
  parameter int               WIDTH        = 13,
  parameter int               WARMUP       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seed_valid,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_seed_ready,
  output logic             o_lfsr_rst,
  output logic [WIDTH-1:0] o_lfsr_seed,
  input  logic [WIDTH-1:0] i_lfsr_state,
  output logic             o_rnd_valid,
  output logic [WIDTH-1:0] o_rnd_data,
  input  logic             i_rnd_ready,
  output logic             o_busy,
  output logic             o_zero_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WARM = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

  state_t           state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             lfsr_rst_reg, lfsr_rst_next;
  logic [WIDTH-1:0] lfsr_seed_reg, lfsr_seed_next;
  logic             rnd_valid_reg, rnd_valid_next;
  logic [WIDTH-1:0] rnd_data_reg, rnd_data_next;
  logic             busy_reg, busy_next;
  logic             zero_err_reg, zero_err_next;

  logic seed_ready;
  logic seed_take;
  logic slot_free;
  logic state_zero;

  assign seed_ready = (state_reg == S_IDLE) || (state_reg == S_RUN);
  assign seed_take  = i_seed_valid && seed_ready;
  assign slot_free  = !rnd_valid_reg || i_rnd_ready;
  assign state_zero = (i_lfsr_state == '0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    lfsr_seed_next = lfsr_seed_reg;
    rnd_valid_next = rnd_valid_reg;
    rnd_data_next  = rnd_data_reg;
    zero_err_next  = zero_err_reg;

    case (state_reg)
      S_IDLE: begin
        if (seed_take) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_next = WARMUP_CNT;
        if (WARMUP_CNT == 8'd0) begin
          state_next = S_RUN;
        end else begin
          state_next = S_WARM;
        end
      end
      S_WARM: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg <= 8'd1) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (state_zero) begin
          zero_err_next = 1'b1;
        end
        // A new seed wins over capture; any pending word is dropped below.
        if (seed_take) begin
          state_next = S_LOAD;
        end else if (slot_free) begin
          if (!state_zero) begin
            rnd_valid_next = 1'b1;
            rnd_data_next  = i_lfsr_state;
          end else begin
            rnd_valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (seed_take) begin
      lfsr_seed_next = (i_seed == '0) ? DEFAULT_SEED : i_seed;
      zero_err_next  = 1'b0;
      rnd_valid_next = 1'b0;
    end

    // Registered decodes of the upcoming state so the pins change with the state.
    lfsr_rst_next = (state_next == S_LOAD);
    busy_next     = (state_next == S_LOAD) || (state_next == S_WARM);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 8'd0;
      lfsr_rst_reg  <= 1'b0;
      lfsr_seed_reg <= DEFAULT_SEED;
      rnd_valid_reg <= 1'b0;
      rnd_data_reg  <= '0;
      busy_reg      <= 1'b0;
      zero_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      lfsr_rst_reg  <= lfsr_rst_next;
      lfsr_seed_reg <= lfsr_seed_next;
      rnd_valid_reg <= rnd_valid_next;
      rnd_data_reg  <= rnd_data_next;
      busy_reg      <= busy_next;
      zero_err_reg  <= zero_err_next;
    end
  end

  assign o_seed_ready = seed_ready;
  assign o_lfsr_rst   = lfsr_rst_reg;
  assign o_lfsr_seed  = lfsr_seed_reg;
  assign o_rnd_valid  = rnd_valid_reg;
  assign o_rnd_data   = rnd_data_reg;
  assign o_busy       = busy_reg;
  assign o_zero_err   = zero_err_reg;

endmodule

// File: doc/prng_seq_ctrl.md
Name: prng_seq_ctrl

Overview:
Sequencer for the 13-bit two-step LFSR of the Massey-Rueppel PRNG. It accepts seeds from a host, loads them into the LFSR through the LFSR's seed/reset pins, discards a programmable number of warm-up steps, then serves LFSR states to a consumer over a valid/ready handshake. It also guards against the all-zero lock-up state.

Parameters:
WIDTH, 13, LFSR state width; fixed to match the LFSR.
WARMUP, 16, LFSR steps (clock cycles) discarded after each load; range 0..255.
DEFAULT_SEED, 13'h0001, substitute for a zero seed; also the o_lfsr_seed value out of reset.

Ports:
i_clk  in  1  clock; single clock domain.
i_rst  in  1  synchronous, active-high reset.
i_seed_valid  in  1  host offers a seed.
i_seed  in  WIDTH  seed value.
o_seed_ready  out  1  seed can be accepted; high in IDLE and RUN.
o_lfsr_rst  out  1  drives the LFSR reset/load pin.
o_lfsr_seed  out  WIDTH  drives the LFSR seed input.
i_lfsr_state  in  WIDTH  current LFSR state.
o_rnd_valid  out  1  o_rnd_data holds an unconsumed word.
o_rnd_data  out  WIDTH  random word.
i_rnd_ready  in  1  consumer accepts the word.
o_busy  out  1  high in LOAD and WARM.
o_zero_err  out  1  sticky flag: the LFSR was seen at zero in RUN.

Behaviour:
- Reset values: state IDLE, o_lfsr_rst=0, o_lfsr_seed=DEFAULT_SEED, o_rnd_valid=0, o_rnd_data=0, o_busy=0, o_zero_err=0, warm-up counter=0.
- All outputs are registered except o_seed_ready, which decodes the state.
- The LFSR advances every clock and has no enable. The controller never stalls it. Any states not captured are lost by design.
- Seed accept: a seed is accepted when i_seed_valid && o_seed_ready at edge T.
  - o_lfsr_seed is loaded with i_seed, or DEFAULT_SEED if i_seed==0.
  - State goes to LOAD.
  - o_zero_err clears.
  - o_rnd_valid clears.
- LOAD, 1 cycle (T+1): o_lfsr_rst=1 and o_busy=1. The LFSR holds the seed from T+2.
  - Next state is WARM with counter=WARMUP, or RUN if WARMUP==0.
- WARM: o_lfsr_rst=0, o_busy=1. The counter decrements each cycle. When it reaches 1, the next state is RUN.
  - WARM lasts exactly WARMUP cycles, T+2 .. T+1+WARMUP.
- RUN (from T+2+WARMUP):
  - Capture condition: (!o_rnd_valid || i_rnd_ready) && i_lfsr_state!=0.
    - When true, o_rnd_data<=i_lfsr_state and o_rnd_valid<=1.
    - When the slot frees but the state is 0, o_rnd_valid<=0.
  - While o_rnd_valid && !i_rnd_ready, o_rnd_data is held stable.
  - First word: visible at T+3+WARMUP. It equals the seed advanced WARMUP LFSR steps.
  - With i_rnd_ready held high, one new word is delivered per cycle.
- Zero guard: in RUN, i_lfsr_state==0 sets o_zero_err.
  - It stays set until the next seed accept or reset.
  - Zero is never delivered as a word.
- Seed offered in LOAD or WARM: o_seed_ready=0, so the seed is not taken. The host must hold it.
- Seed accept in RUN in the same cycle as a consumer handshake:
  - The consumer handshake completes, and that word counts as delivered.
  - o_rnd_valid=0 from T+1.
  - An unconsumed pending word is discarded.
- IDLE: no words are produced. o_lfsr_rst=0.
- i_rst at any point, including mid-LOAD or mid-WARM, returns all registers to their reset values at the next edge.

Test Plan:
- Seed 13'h0001, WARMUP=0, ready high: o_busy high 1 cycle. o_rnd_valid rises at T+3 with data 13'h0001. Next word 13'h1800.
- Seed 13'h0001, WARMUP=1: o_busy high 2 cycles. First word at T+4 = 13'h1800.
- Seed 0: o_lfsr_seed=13'h0001 during LOAD. Words match the seed-1 scenario.
- RUN, ready held low 5 cycles: o_rnd_data stays constant. After ready rises, it updates the next cycle.
- Seed offered in WARM: o_seed_ready=0 and the seed is not taken. It is accepted on the first RUN cycle, with a new LOAD and valid dropped.
- Bench forces i_lfsr_state=0 in RUN: o_zero_err=1 and valid drops once the slot frees. A new seed clears the flag. i_rst mid-WARM returns to IDLE with o_busy=0.
